serial_alu_seq: RTL

Bit-serial add/subtract sequencer that time-shares a single `full_adder` cell across all bits of a WIDTH-bit operation. It holds the carry in a flip-flop between cycles and steps through the operands one bit per clock. It sits beside the 32-bit ALU as the low-area arithmetic path, under a start/done handshake. One operation is in flight at a time.

---
 rtl/serial_alu_pkg.sv | 15 +
 rtl/full_adder.sv | 15 +
 rtl/serial_alu_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial add/subtract sequencer.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial sequencer.
// Latency: combinational.
// Backpressure: not applicable.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial add/sub over one full_adder; signed overflow output only with SERIAL_ALU_SEQ_OVF_EN.
// Latency: done pulses WIDTH+1 cycles after start is sampled; one op per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy/done are dropped, not queued.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
`ifdef SERIAL_ALU_SEQ_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] sa, sb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] sa_next;

    full_adder u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // Sum bits enter at the top so that after WIDTH shifts sa holds the full result.
    assign sa_next = {fa_s, sa[WIDTH-1:1]};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
`ifdef SERIAL_ALU_SEQ_OVF_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= (op == OP_SUB) ? ~b : b;
                        carry <= (op == OP_SUB);
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sa    <= sa_next;
                    sb    <= sb >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result <= sa_next;
                        cout   <= fa_c;
                        zero   <= (sa_next == '0);
`ifdef SERIAL_ALU_SEQ_OVF_EN
                        // carry holds the carry into the MSB on this final step
                        overflow <= carry ^ fa_c;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
